// File: rtl/moving_average_var.sv
// Variable-length moving average over signed samples, window 2^k (k <= LOG_MAX).
// Ports: clk, reset (sync, high), in_data/in_valid, window_log2/window_load -> out_data/out_valid, primed, window_active.
module moving_average_var #(
  parameter int SIZE_DATA       = 16,
  parameter int SIZE_MAX_WINDOW = 64,
  parameter int SIZE_WINDOW     = 8,
  localparam int LOG_MAX        = $clog2(SIZE_MAX_WINDOW),
  localparam int SIZE_ACC       = SIZE_DATA + LOG_MAX,
  localparam int SIZE_WL        = $clog2(LOG_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [SIZE_DATA-1:0] in_data,
  input  logic                        in_valid,
  input  logic        [SIZE_WL-1:0]   window_log2,
  input  logic                        window_load,
  output logic signed [SIZE_DATA-1:0] out_data,
  output logic                        out_valid,
  output logic                        primed,
  output logic        [SIZE_WL-1:0]   window_active
);

  localparam logic [SIZE_WL-1:0] WA_RST = SIZE_WL'($clog2(SIZE_WINDOW));
  localparam logic [SIZE_WL-1:0] WL_MAX = SIZE_WL'(LOG_MAX);

  logic signed [SIZE_DATA-1:0] mem [SIZE_MAX_WINDOW];

  logic        [LOG_MAX-1:0]   wr_ptr;
  logic        [LOG_MAX:0]     fill;
  logic signed [SIZE_ACC-1:0]  acc;

  logic        [SIZE_WL-1:0]   wa_req;
  logic        [SIZE_WL-1:0]   wa_next;
  logic        [LOG_MAX:0]     w_next;
  logic        [LOG_MAX:0]     fill_base;
  logic signed [SIZE_ACC-1:0]  acc_base;
  logic                        full;
  logic        [LOG_MAX-1:0]   leave_idx;
  logic signed [SIZE_DATA-1:0] leave_raw;
  logic signed [SIZE_ACC-1:0]  leaving;
  logic signed [SIZE_ACC-1:0]  in_ext;
  logic signed [SIZE_ACC-1:0]  acc_sum;
  logic        [LOG_MAX:0]     fill_sum;
  logic signed [SIZE_DATA-1:0] avg;

  // A load flushes before the same-cycle sample is counted, so the
  // sample is evaluated against the cleared state and the new window.
  always_comb begin
    wa_req    = (window_log2 > WL_MAX) ? WL_MAX : window_log2;
    wa_next   = window_load ? wa_req : window_active;
    w_next    = (LOG_MAX + 1)'(1) << wa_next;
    fill_base = window_load ? '0 : fill;
    acc_base  = window_load ? '0 : acc;
    full      = (fill_base == w_next);
    // Oldest sample of a full window sits W slots behind the write pointer.
    leave_idx = wr_ptr - w_next[LOG_MAX-1:0];
    leave_raw = mem[leave_idx];
    leaving   = full
              ? {{LOG_MAX{leave_raw[SIZE_DATA-1]}}, leave_raw}
              : '0;
    in_ext    = {{LOG_MAX{in_data[SIZE_DATA-1]}}, in_data};
    // The result holds at most W samples, so it always fits SIZE_ACC.
    acc_sum   = acc_base + in_ext - leaving;
    fill_sum  = full ? fill_base : fill_base + 1'b1;
    avg       = SIZE_DATA'(acc_sum >>> wa_next);
  end

  always_ff @(posedge clk) begin
    if (!reset && in_valid) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc           <= '0;
      fill          <= '0;
      wr_ptr        <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      primed        <= 1'b0;
      window_active <= WA_RST;
    end else begin
      out_valid <= 1'b0;
      if (window_load) begin
        window_active <= wa_req;
        acc           <= '0;
        fill          <= '0;
        primed        <= 1'b0;
      end
      if (in_valid) begin
        acc    <= acc_sum;
        fill   <= fill_sum;
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_sum == w_next) begin
          out_valid <= 1'b1;
          out_data  <= avg;
          primed    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_moving_average_var.sv
// Self-checking bench for moving_average_var with a queue-based reference.
// Drives directed scenarios and randomized traffic, compares every cycle.
module tb_moving_average_var;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic        [2:0]  window_log2;
  logic               window_load;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               primed;
  logic        [2:0]  window_active;

  int errors = 0;
  int checks = 0;

  int                 hist[$];
  logic               m_valid;
  logic signed [15:0] m_out;
  logic               m_primed;
  logic        [2:0]  m_wa;

  always #5 clk = ~clk;

  moving_average_var dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .window_log2(window_log2),
    .window_load(window_load),
    .out_data(out_data),
    .out_valid(out_valid),
    .primed(primed),
    .window_active(window_active)
  );

  // One clock with the given inputs, then advance the reference model.
  task automatic cycle(input logic rst, input logic v, input logic ld,
                       input logic [2:0] wl, input int d);
    int w;
    int sum;
    reset = rst;
    in_valid = v;
    window_load = ld;
    window_log2 = wl;
    in_data = 16'(d);
    @(posedge clk);
    #1;
    if (rst) begin
      hist.delete();
      m_wa = 3'd3;
      m_valid = 1'b0;
      m_out = '0;
      m_primed = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (ld) begin
        m_wa = (wl > 3'd6) ? 3'd6 : wl;
        hist.delete();
        m_primed = 1'b0;
      end
      if (v) begin
        w = 1 << m_wa;
        hist.push_back(d);
        if (hist.size() > w) void'(hist.pop_front());
        if (hist.size() == w) begin
          sum = 0;
          foreach (hist[i]) sum += hist[i];
          m_out = 16'((sum >= 0) ? sum / w : -((-sum + w - 1) / w));
          m_valid = 1'b1;
          m_primed = 1'b1;
        end
      end
    end
    reset = 1'b0;
    in_valid = 1'b0;
    window_load = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 5, 123);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || primed !== 1'b0 ||
        window_active !== 3'd3) begin
      errors++;
      $display("FAIL reset: valid=%b data=%0d primed=%b wa=%0d want 0 0 0 3",
               out_valid, out_data, primed, window_active);
    end
  endtask

  task automatic test_defaults();
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0, 100);
      checks++;
      if (out_valid !== m_valid || out_data !== m_out ||
          primed !== m_primed || window_active !== m_wa) begin
        errors++;
        $display("FAIL defaults[%0d]: v=%b d=%0d p=%b want v=%b d=%0d p=%b",
                 i, out_valid, out_data, primed, m_valid, m_out, m_primed);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd100 || primed !== 1'b1) begin
      errors++;
      $display("FAIL defaults_final: v=%b d=%0d p=%b want 1 100 1",
               out_valid, out_data, primed);
    end
  endtask

  task automatic test_sliding();
    cycle(0, 0, 1, 3, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, i * 8);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd28) begin
      errors++;
      $display("FAIL sliding_28: v=%b d=%0d want 1 28", out_valid, out_data);
    end
    cycle(0, 1, 0, 0, 64);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd36 || out_data !== m_out) begin
      errors++;
      $display("FAIL sliding_36: v=%b d=%0d want 1 36", out_valid, out_data);
    end
  endtask

  task automatic test_negatives();
    int s[4] = '{-3, -3, -3, -2};
    cycle(0, 0, 1, 2, 0);
    foreach (s[i]) cycle(0, 1, 0, 0, s[i]);
    checks++;
    if (out_valid !== 1'b1 || out_data !== -16'sd3 || out_data !== m_out) begin
      errors++;
      $display("FAIL negatives: v=%b d=%0d want 1 -3", out_valid, out_data);
    end
  endtask

  task automatic test_reconfig();
    cycle(0, 0, 1, 3, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, $urandom_range(0, 500));
    checks++;
    if (primed !== 1'b1) begin
      errors++;
      $display("FAIL reconfig_primed: primed=%b want 1", primed);
    end
    cycle(0, 1, 1, 2, 40);
    checks++;
    if (primed !== 1'b0 || out_valid !== 1'b0 || window_active !== 3'd2) begin
      errors++;
      $display("FAIL reconfig_flush: p=%b v=%b wa=%0d want 0 0 2",
               primed, out_valid, window_active);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 40);
      checks++;
      if (out_valid !== m_valid || out_data !== m_out || primed !== m_primed) begin
        errors++;
        $display("FAIL reconfig[%0d]: v=%b d=%0d p=%b want v=%b d=%0d p=%b",
                 i, out_valid, out_data, primed, m_valid, m_out, m_primed);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'sd40 || primed !== 1'b1) begin
      errors++;
      $display("FAIL reconfig_out: v=%b d=%0d p=%b want 1 40 1",
               out_valid, out_data, primed);
    end
  endtask

  task automatic test_extremes();
    cycle(0, 0, 1, 6, 0);
    for (int i = 0; i < 64; i++) cycle(0, 1, 0, 0, -32768);
    checks++;
    if (out_valid !== 1'b1 || out_data !== -16'sd32768) begin
      errors++;
      $display("FAIL extremes_min: v=%b d=%0d want 1 -32768", out_valid, out_data);
    end
    cycle(0, 1, 0, 0, -32768);
    checks++;
    if (out_valid !== 1'b1 || out_data !== -16'sd32768) begin
      errors++;
      $display("FAIL extremes_slide: v=%b d=%0d want 1 -32768", out_valid, out_data);
    end
    cycle(0, 0, 1, 7, 0);
    checks++;
    if (window_active !== 3'd6 || primed !== 1'b0) begin
      errors++;
      $display("FAIL extremes_clamp: wa=%0d p=%b want 6 0", window_active, primed);
    end
  endtask

  task automatic test_w1_idle();
    int d;
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 65535)) - 32768;
      cycle(0, 1, 0, 0, d);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(d)) begin
        errors++;
        $display("FAIL w1[%0d]: v=%b d=%0d want 1 %0d", i, out_valid, out_data, d);
      end
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'(d) || primed !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold[%0d]: v=%b d=%0d p=%b want 0 %0d 1",
                 i, out_valid, out_data, primed, d);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 1, 3, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 50 + i);
    cycle(1, 1, 0, 0, 999);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'sd0 || primed !== 1'b0 ||
        window_active !== 3'd3) begin
      errors++;
      $display("FAIL reset_mid: v=%b d=%0d p=%b wa=%0d want 0 0 0 3",
               out_valid, out_data, primed, window_active);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 0, 10 * i);
      checks++;
      if (out_valid !== (i == 7) || out_data !== m_out || primed !== m_primed) begin
        errors++;
        $display("FAIL reset_refill[%0d]: v=%b d=%0d want v=%b d=%0d",
                 i, out_valid, out_data, i == 7, m_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 29) == 0,
            3'($urandom_range(0, 7)),
            int'($urandom_range(0, 65535)) - 32768);
      checks++;
      if (out_valid !== m_valid || out_data !== m_out ||
          primed !== m_primed || window_active !== m_wa) begin
        errors++;
        $display("FAIL random[%0d]: v=%b d=%0d p=%b wa=%0d want %b %0d %b %0d",
                 i, out_valid, out_data, primed, window_active,
                 m_valid, m_out, m_primed, m_wa);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    window_load = 1'b0;
    window_log2 = '0;
    m_wa = 3'd3;
    m_valid = 1'b0;
    m_out = '0;
    m_primed = 1'b0;
    test_reset();
    test_defaults();
    test_sliding();
    test_negatives();
    test_reconfig();
    test_extremes();
    test_w1_idle();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moving_average_var.md
MOVING_AVERAGE_VAR -- requirements
Module: moving_average_var

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 16: sample width, two's-complement signed.
REQ-002 SHALL have parameter SIZE_MAX_WINDOW, default 64: buffer depth and largest window; power of two, at least 2.
REQ-003 SHALL have parameter SIZE_WINDOW, default 8: window length in effect after reset; power of two, at most SIZE_MAX_WINDOW.
REQ-004 SHALL have derived constant LOG_MAX = log2(SIZE_MAX_WINDOW) and accumulator width SIZE_ACC = SIZE_DATA + LOG_MAX.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port in_data, input, SIZE_DATA bits: signed sample.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is accepted on this cycle.
REQ-009 SHALL have port window_log2, input, clog2(LOG_MAX+1) bits: requested log2 of the window, sampled only when window_load=1.
REQ-010 SHALL have port window_load, input, 1 bit: single-cycle request to apply window_log2 and flush.
REQ-011 SHALL have port out_data, output, SIZE_DATA bits: signed average.
REQ-012 SHALL have port out_valid, output, 1 bit: single-cycle qualifier for out_data.
REQ-013 SHALL have port primed, output, 1 bit: level high while the current window is completely filled.
REQ-014 SHALL have port window_active, output, clog2(LOG_MAX+1) bits: log2 of the window in effect.

Function
REQ-015 SHALL store every accepted sample in a circular buffer of SIZE_MAX_WINDOW entries, with the write pointer incrementing modulo SIZE_MAX_WINDOW per accepted sample.
REQ-016 SHALL keep a fill counter that saturates at W = 2^window_active.
REQ-017 SHALL update, per accepted sample, acc <= acc + in_data - leaving; leaving = buffer[(wr_ptr - W) mod SIZE_MAX_WINDOW] when fill counter = W, otherwise 0.
REQ-018 SHALL perform all arithmetic sign-extended to SIZE_ACC bits, and the accumulator SHALL never overflow.
REQ-019 SHALL compute out_data as the new acc arithmetically shifted right by window_active bits (floor toward minus infinity), truncated to SIZE_DATA bits.
REQ-020 SHALL register out_data and pulse out_valid exactly one clk after an accepted sample, and only when that sample brings or keeps the fill counter at W.
REQ-021 SHALL leave out_data unchanged when out_valid=0, keeping its last value.
REQ-022 SHALL, with in_valid=0, leave all state unchanged; no output pulse.
REQ-023 SHALL raise primed in the same cycle as the first out_valid of a window; primed SHALL fall on flush.
REQ-024 SHALL, on window_load=1, set window_active to min(window_log2, LOG_MAX) on the next edge; the clamped value applies to out-of-range requests, e.g. 7 with LOG_MAX=6 gives 6.
REQ-025 SHALL, on window_load=1, flush: clear acc, fill counter and primed; buffer contents and write pointer SHALL be left as they are.
REQ-026 SHALL, on simultaneous window_load=1 and in_valid=1, apply the flush first and count that sample as the first sample of the new window (acc = in_data, fill = 1).
REQ-027 SHALL accept window_log2 = 0 (W = 1), giving out_data = in_data one cycle later with out_valid on every accepted sample.
REQ-028 SHALL accept back-to-back in_valid on every cycle at full rate, with no stall and no ready signal.

Reset
REQ-029 SHALL, while reset=1 at an edge, clear acc, fill counter, write pointer, out_data, out_valid and primed to 0, and set window_active to log2(SIZE_WINDOW).
REQ-030 SHALL give reset priority over window_load and in_valid; a sample presented during reset SHALL be discarded.
REQ-031 SHALL, on reset in mid-window, discard the partial window; the first out_valid after release SHALL follow W new samples.
REQ-032 SHALL not require buffer contents to be reset.

Verification
REQ-033 SHALL cover defaults: 8 samples of 100 -> no out_valid for samples 1-7; out_valid with out_data=100 one cycle after sample 8; primed=1.
REQ-034 SHALL cover sliding: W=8, samples 0,8,16,...,56 then 64 -> outputs 28 and then 36.
REQ-035 SHALL cover negatives: W=4, samples -3,-3,-3,-2 -> out_data=-3 (floor of -2.75).
REQ-036 SHALL cover reconfiguration: W=8 primed, then window_load with window_log2=2 together with sample 40, followed by 40,40,40 -> primed drops; out_valid with 40 after the 4th sample; window_active=2.
REQ-037 SHALL cover extremes: window_log2=6, 64 samples of -32768 -> out_data=-32768 with no overflow; then window_log2=7 -> window_active=6.
REQ-038 SHALL cover reset: reset after sample 5 of W=8, with in_valid high during reset -> outputs 0 and window_active=3; 8 further samples required before out_valid.
